instr_fetch: RTL



---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 89 ++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake plus the core-facing instruction/redirect signals.
// The fetch unit uses the master modport; memory and core (or a bench) use the slave modport.
interface instr_fetch_if;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        STALL;
    logic        PC_LOAD;
    logic [31:0] PC_TARGET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        FETCH_ERROR;

    modport master (
        output IMEM_READ, IMEM_ADDRESS, PC, INSTRUCTION, INSTR_VALID, FETCH_ERROR,
        input  IMEM_READDATA, IMEM_BUSYWAIT, STALL, PC_LOAD, PC_TARGET
    );

    modport slave (
        input  IMEM_READ, IMEM_ADDRESS, PC, INSTRUCTION, INSTR_VALID, FETCH_ERROR,
        output IMEM_READDATA, IMEM_BUSYWAIT, STALL, PC_LOAD, PC_TARGET
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per transaction over a read/busywait
// handshake, presents it for one cycle (or longer under stall), and latches a sticky timeout error.
module instr_fetch #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned PC_STEP       = 4,
    parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
    input  logic          CLK,
    input  logic          RESET,
    instr_fetch_if.master bus
);
    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_q, wait_d;
    logic        read_q, read_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (!bus.IMEM_BUSYWAIT) begin
                    instr_d = bus.IMEM_READDATA;
                    wait_d  = '0;
                    state_d = S_VALID;
                end else if (wait_q == FETCH_TIMEOUT) begin
                    // FETCH_TIMEOUT busy cycles were tolerated; one more is fatal.
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_VALID: begin
                if (!bus.STALL) begin
                    pc_d    = bus.PC_LOAD ? bus.PC_TARGET : pc_q + STEP;
                    state_d = S_FETCH;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
        // Status outputs are flopped copies of the next-state decode, so they track state_q exactly.
        read_d  = (state_d == S_FETCH);
        valid_d = (state_d == S_VALID);
        err_d   = (state_d == S_ERROR);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            read_q  <= read_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.IMEM_READ    = read_q;
    assign bus.IMEM_ADDRESS = pc_q;
    assign bus.PC           = pc_q;
    assign bus.INSTRUCTION  = instr_q;
    assign bus.INSTR_VALID  = valid_q;
    assign bus.FETCH_ERROR  = err_q;
endmodule
